// File: rtl/iir_ctrl_pkg.sv
// Shared definitions for the IIR coefficient controller: register map, CTRL bits,
// commit FSM states and the packed coefficient set.
package iir_ctrl_pkg;

  localparam int unsigned COEF_W         = 136;
  localparam int unsigned NUM_COEF_BYTES = 17;

  localparam logic [4:0] ADDR_CX   = 5'd0;
  localparam logic [4:0] ADDR_CX0  = 5'd5;
  localparam logic [4:0] ADDR_CX1  = 5'd6;
  localparam logic [4:0] ADDR_CX2  = 5'd7;
  localparam logic [4:0] ADDR_CY0  = 5'd8;
  localparam logic [4:0] ADDR_CY1  = 5'd11;
  localparam logic [4:0] ADDR_CY2  = 5'd14;
  localparam logic [4:0] ADDR_CTRL = 5'd17;

  localparam int unsigned CTRL_COMMIT = 0;
  localparam int unsigned CTRL_FLUSH  = 1;
  localparam int unsigned CTRL_ENABLE = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FLUSH
  } commit_state_t;

  // Member order makes shadow byte N sit at bits [8N+7:8N] of the packed value.
  typedef struct packed {
    logic [23:0] cy2;
    logic [23:0] cy1;
    logic [23:0] cy0;
    logic [7:0]  cx2;
    logic [7:0]  cx1;
    logic [7:0]  cx0;
    logic [39:0] cx;
  } coef_t;

  function automatic logic [7:0] ctrl_status(input logic enable, input logic flush,
                                             input logic pending);
    return {5'b0, enable, flush, pending};
  endfunction

endpackage

// File: rtl/iir_ce_gen.sv
// Fractional phase accumulator producing the filter ce strobe and the
// sample_ce strobe on the second pulse of each channel pair.
module iir_ce_gen #(
  parameter int unsigned        PHASE_W   = 32,
  parameter logic [PHASE_W-1:0] PHASE_INC = 32'd6871948
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic hold,
  output logic ce,
  output logic sample_ce
);

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W:0]   sum;
  logic               ch;
  logic               advance;
  logic               carry;

  assign sum     = {1'b0, acc} + {1'b0, PHASE_INC};
  assign advance = enable & ~hold;
  assign carry   = advance & sum[PHASE_W];

  // While held the accumulator freezes, so a pending carry is deferred, not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      ce        <= 1'b0;
      sample_ce <= 1'b0;
      ch        <= 1'b0;
    end else begin
      if (!enable)
        acc <= '0;
      else if (advance)
        acc <= sum[PHASE_W-1:0];
      ce        <= carry;
      sample_ce <= carry & ch;
      if (hold)
        ch <= 1'b0;
      else if (carry)
        ch <= ~ch;
    end
  end

endmodule

// File: rtl/iir_coef_ctrl.sv
// Sequencer and coefficient manager for the two-channel 3-tap IIR filter:
// shadow register file, atomic commit at stereo-pair boundaries, flush pulse.
module iir_coef_ctrl
  import iir_ctrl_pkg::*;
#(
  parameter int unsigned        PHASE_W   = 32,
  parameter logic [PHASE_W-1:0] PHASE_INC = 32'd6871948,
  parameter logic [39:0]        DEF_CX    = 40'h0,
  parameter logic [23:0]        DEF_CXN   = 24'h0,
  parameter logic [71:0]        DEF_CY    = 72'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [4:0]  addr,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  output logic        ce,
  output logic        sample_ce,
  output logic        filt_reset,
  output logic [39:0] cx,
  output logic [7:0]  cx0,
  output logic [7:0]  cx1,
  output logic [7:0]  cx2,
  output logic [23:0] cy0,
  output logic [23:0] cy1,
  output logic [23:0] cy2,
  output logic        pending
);

  localparam coef_t DEF_COEF = {DEF_CY, DEF_CXN, DEF_CX};

  coef_t         shadow;
  coef_t         active;
  commit_state_t state;
  logic          enable_q;
  logic          flush_q;
  logic          qflush_q;
  logic          flush_cnt;
  logic          ctrl_wr;
  logic          commit_req;
  logic          flush_req;

  assign ctrl_wr    = wr_en && (addr == ADDR_CTRL);
  assign commit_req = ctrl_wr && wr_data[CTRL_COMMIT];
  assign flush_req  = wr_data[CTRL_FLUSH];

  iir_ce_gen #(
    .PHASE_W  (PHASE_W),
    .PHASE_INC(PHASE_INC)
  ) u_ce_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable_q),
    .hold     (filt_reset),
    .ce       (ce),
    .sample_ce(sample_ce)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow   <= DEF_COEF;
      enable_q <= 1'b0;
    end else if (wr_en) begin
      if (addr < ADDR_CTRL)
        shadow[{addr, 3'b000} +: 8] <= wr_data;
      else if (addr == ADDR_CTRL)
        enable_q <= wr_data[CTRL_ENABLE];
    end
  end

  always_comb begin
    rd_data = '0;
    if (addr < ADDR_CTRL)
      rd_data = shadow[{addr, 3'b000} +: 8];
    else if (addr == ADDR_CTRL)
      rd_data = ctrl_status(enable_q, flush_q, pending);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      active     <= DEF_COEF;
      pending    <= 1'b0;
      flush_q    <= 1'b0;
      qflush_q   <= 1'b0;
      filt_reset <= 1'b0;
      flush_cnt  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (commit_req) begin
            pending <= 1'b1;
            flush_q <= flush_req;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (commit_req)
            flush_q <= flush_q | flush_req;
          // Swapping on the sample_ce edge keeps each channel pair on one coefficient set.
          if (!enable_q || sample_ce) begin
            active  <= shadow;
            pending <= 1'b0;
            if (flush_q || (commit_req && flush_req)) begin
              state      <= FLUSH;
              filt_reset <= 1'b1;
              flush_cnt  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (commit_req) begin
            pending  <= 1'b1;
            qflush_q <= qflush_q | flush_req;
          end
          if (flush_cnt) begin
            filt_reset <= 1'b0;
            qflush_q   <= 1'b0;
            // A commit queued during the flush proceeds straight to WAIT.
            if (pending || commit_req) begin
              state   <= WAIT;
              flush_q <= qflush_q | (commit_req & flush_req);
            end else begin
              state   <= IDLE;
              flush_q <= 1'b0;
            end
          end else begin
            flush_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cx  = active.cx;
  assign cx0 = active.cx0;
  assign cx1 = active.cx1;
  assign cx2 = active.cx2;
  assign cy0 = active.cy0;
  assign cy1 = active.cy1;
  assign cy2 = active.cy2;

endmodule

// File: tb/tb_iir_coef_ctrl.sv
// Randomized self-checking bench for iir_coef_ctrl against a cycle-level
// behavioural model of strobes, shadow/active sets and commit sequencing.
module tb_iir_coef_ctrl;

  localparam logic [31:0] INC  = 32'h4000_0000;
  localparam logic [39:0] DCX  = 40'hC3_5A_A5_0F_F0;
  localparam logic [23:0] DCXN = 24'h7E_81_3C;
  localparam logic [71:0] DCY  = 72'h9A_BC_DE_F0_12_34_56_78_9A;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [4:0]  addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        ce, sample_ce, filt_reset, pending;
  logic [39:0] cx;
  logic [7:0]  cx0, cx1, cx2;
  logic [23:0] cy0, cy1, cy2;

  always #5 clk = ~clk;

  iir_coef_ctrl #(
    .PHASE_W  (32),
    .PHASE_INC(INC),
    .DEF_CX   (DCX),
    .DEF_CXN  (DCXN),
    .DEF_CY   (DCY)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .ce(ce), .sample_ce(sample_ce), .filt_reset(filt_reset),
    .cx(cx), .cx0(cx0), .cx1(cx1), .cx2(cx2), .cy0(cy0), .cy1(cy1), .cy2(cy2),
    .pending(pending)
  );

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model state
  logic [7:0] sh [17];
  logic [7:0] act[17];
  longint     k;
  logic       ce_m, sce_m, ch_m, en_m, pend_m, fq_m, qf_m, wait_m;
  int         fl_left;

  task automatic model_reset();
    logic [135:0] d;
    d = {DCY, DCXN, DCX};
    for (int i = 0; i < 17; i++) begin
      sh[i]  = d[8*i +: 8];
      act[i] = d[8*i +: 8];
    end
    k = 0; ce_m = 0; sce_m = 0; ch_m = 0; en_m = 0;
    pend_m = 0; fq_m = 0; qf_m = 0; wait_m = 0; fl_left = 0;
  endtask

  // One clock edge: ce fires when k*INC crosses a multiple of 2^32.
  task automatic model_edge(input logic we, input logic [4:0] a, input logic [7:0] d);
    logic commit, fl, carry, n_ch;
    commit = we && (a == 5'd17) && d[0];
    fl     = d[1];
    carry  = 1'b0;
    if (!en_m)
      k = 0;
    else if (fl_left == 0) begin
      k++;
      carry = ((k * longint'(INC)) >> 32) != (((k - 1) * longint'(INC)) >> 32);
    end
    n_ch = (fl_left > 0) ? 1'b0 : (ch_m ^ carry);

    if (fl_left > 0) begin
      if (commit) begin pend_m = 1; qf_m = qf_m | fl; end
      fl_left--;
      if (fl_left == 0) begin
        fq_m   = pend_m ? qf_m : 1'b0;
        wait_m = pend_m;
        qf_m   = 0;
      end
    end else if (wait_m) begin
      if (commit) fq_m = fq_m | fl;
      if (!en_m || sce_m) begin
        for (int i = 0; i < 17; i++) act[i] = sh[i];
        pend_m = 0;
        wait_m = 0;
        if (fq_m) fl_left = 2;
      end
    end else if (commit) begin
      pend_m = 1; fq_m = fl; wait_m = 1;
    end

    if (we && a < 5'd17) sh[a] = d;
    if (we && a == 5'd17) en_m = d[2];
    sce_m = carry & ch_m;
    ce_m  = carry;
    ch_m  = n_ch;
  endtask

  function automatic logic [7:0] md_rd(input logic [4:0] a);
    if (a < 5'd17) return sh[a];
    if (a == 5'd17) return {5'b0, en_m, fq_m, pend_m};
    return 8'h00;
  endfunction

  function automatic logic [139:0] obs_dut();
    return {ce, sample_ce, pending, filt_reset, cy2, cy1, cy0, cx2, cx1, cx0, cx};
  endfunction

  function automatic logic [139:0] obs_mdl();
    logic [135:0] a;
    for (int i = 0; i < 17; i++) a[8*i +: 8] = act[i];
    return {ce_m, sce_m, pend_m, (fl_left > 0), a};
  endfunction

  task automatic tick(input logic we, input logic [4:0] a, input logic [7:0] d);
    wr_en = we; addr = a; wr_data = d;
    @(posedge clk);
    model_edge(we, a, d);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (obs_dut() !== obs_mdl()) begin
      mismatched++;
      $display("FAIL reset_outputs got=%h exp=%h", obs_dut(), obs_mdl());
    end
    for (int i = 0; i < 19; i++) begin
      addr = 5'(i);
      #1;
      compared++;
      if (rd_data !== md_rd(addr)) begin
        mismatched++;
        $display("FAIL reset_rd addr=%0d got=%h exp=%h", i, rd_data, md_rd(addr));
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_strobes();
    int nce, nsce;
    nce = 0; nsce = 0;
    tick(1'b1, 5'd17, 8'h04);
    repeat (40) begin
      tick(1'b0, 5'd0, 8'h00);
      nce += int'(ce); nsce += int'(sample_ce);
      compared++;
      if (obs_dut() !== obs_mdl()) begin
        mismatched++;
        $display("FAIL strobes got=%h exp=%h", obs_dut(), obs_mdl());
      end
    end
    compared++;
    if (nce != 10 || nsce != 5) begin
      mismatched++;
      $display("FAIL strobe_count ce=%0d sce=%0d exp ce=10 sce=5", nce, nsce);
    end
  endtask

  task automatic test_shadow_write();
    tick(1'b1, 5'd8, 8'h56);
    tick(1'b1, 5'd9, 8'h34);
    tick(1'b1, 5'd10, 8'h12);
    compared++;
    if (cy0 !== DCY[23:0] || obs_dut() !== obs_mdl()) begin
      mismatched++;
      $display("FAIL shadow_no_commit cy0=%h exp=%h", cy0, DCY[23:0]);
    end
    addr = 5'd9;
    #1;
    compared++;
    if (rd_data !== 8'h34) begin
      mismatched++;
      $display("FAIL shadow_read got=%h exp=34", rd_data);
    end
  endtask

  task automatic test_commit();
    int  nce;
    bit  swapped;
    nce = 0; swapped = 0;
    repeat ($urandom_range(0, 7)) tick(1'b0, 5'd0, 8'h00);
    tick(1'b1, 5'd17, 8'h05);
    compared++;
    if (pending !== 1'b1) begin
      mismatched++;
      $display("FAIL commit_pending got=%b exp=1", pending);
    end
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 5'd0, 8'h00);
      compared++;
      if (obs_dut() !== obs_mdl()) begin
        mismatched++;
        $display("FAIL commit_seq cyc=%0d got=%h exp=%h", i, obs_dut(), obs_mdl());
      end
      if (!pend_m) swapped = 1;
      if (swapped && ce && nce < 2) begin
        nce++;
        compared++;
        if (cy0 !== 24'h123456) begin
          mismatched++;
          $display("FAIL commit_ce_coef got=%h exp=123456", cy0);
        end
      end
    end
    compared++;
    if (nce < 2) begin
      mismatched++;
      $display("FAIL commit_timeout ce_after_swap=%0d exp=2", nce);
    end
  endtask

  task automatic test_flush();
    int  frc;
    bit  after, checked;
    frc = 0; after = 0; checked = 0;
    for (int i = 0; i < 4; i++) tick(1'b1, 5'($urandom_range(0, 16)), 8'($urandom));
    tick(1'b1, 5'd17, 8'h07);
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 5'd17, 8'h00);
      compared++;
      if (obs_dut() !== obs_mdl() || rd_data !== md_rd(5'd17)) begin
        mismatched++;
        $display("FAIL flush_seq cyc=%0d got=%h/%h exp=%h/%h", i, obs_dut(), rd_data,
                 obs_mdl(), md_rd(5'd17));
      end
      if (filt_reset) begin
        frc++;
        compared++;
        if (ce !== 1'b0) begin
          mismatched++;
          $display("FAIL flush_ce_during_reset got=%b exp=0", ce);
        end
      end else if (frc > 0) after = 1;
      if (after && ce && !checked) begin
        checked = 1;
        compared++;
        if (sample_ce !== 1'b0) begin
          mismatched++;
          $display("FAIL flush_first_ce_ch got sample_ce=%b exp=0", sample_ce);
        end
      end
    end
    compared++;
    if (frc != 2 || !checked) begin
      mismatched++;
      $display("FAIL flush_len got=%0d exp=2 ce_seen=%0d", frc, checked);
    end
  endtask

  task automatic test_disabled_commit();
    int ph;
    ph = 0;
    tick(1'b1, 5'd17, 8'h00);
    tick(1'b1, 5'd5, 8'($urandom));
    tick(1'b1, 5'd17, 8'h01);
    compared++;
    if (pending !== 1'b1) begin
      mismatched++;
      $display("FAIL dis_pending got=%b exp=1", pending);
    end
    ph += int'(pending);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 5'd0, 8'h00);
      ph += int'(pending);
      compared++;
      if (obs_dut() !== obs_mdl() || ce !== 1'b0) begin
        mismatched++;
        $display("FAIL dis_seq cyc=%0d got=%h exp=%h", i, obs_dut(), obs_mdl());
      end
    end
    compared++;
    if (ph != 1) begin
      mismatched++;
      $display("FAIL dis_pending_len got=%0d exp=1", ph);
    end
  endtask

  task automatic test_random();
    logic [4:0] a;
    logic [7:0] d;
    logic       we;
    tick(1'b1, 5'd17, 8'h04);
    repeat (400) begin
      we = ($urandom_range(0, 99) < 30);
      a  = ($urandom_range(0, 3) == 0) ? 5'd17 : 5'($urandom);
      d  = 8'($urandom);
      if (a == 5'd17) d[2] = ($urandom_range(0, 99) < 85);
      tick(we, a, d);
      compared++;
      if (obs_dut() !== obs_mdl() || rd_data !== md_rd(a)) begin
        mismatched++;
        $display("FAIL random a=%0d got=%h/%h exp=%h/%h", a, obs_dut(), rd_data,
                 obs_mdl(), md_rd(a));
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    tick(1'b1, 5'd17, 8'h04);
    for (int i = 0; i < 50 && (pend_m || fl_left > 0); i++) tick(1'b0, 5'd0, 8'h00);
    compared++;
    if (pend_m || fl_left > 0) begin
      mismatched++;
      $display("FAIL rstwait_idle_timeout pending=%b", pending);
    end
    tick(1'b1, 5'd14, 8'hEE);
    tick(1'b1, 5'd17, 8'h05);
    compared++;
    if (pending !== 1'b1) begin
      mismatched++;
      $display("FAIL rstwait_pending got=%b exp=1", pending);
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    addr = 5'd14;
    #1;
    compared++;
    if (obs_dut() !== obs_mdl() || pending !== 1'b0 || rd_data !== DCY[55:48]) begin
      mismatched++;
      $display("FAIL rstwait_async got=%h rd=%h exp=%h rd=%h", obs_dut(), rd_data,
               obs_mdl(), DCY[55:48]);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_strobes();
    test_shadow_write();
    test_commit();
    test_flush();
    test_disabled_commit();
    test_random();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/iir_coef_ctrl.md
# iir_coef_ctrl

Sequencer and coefficient manager for the two-channel 3-tap IIR audio filter used by expansion-audio mappers. It generates the filter's `ce` strobe at twice the output sample rate and the matching `sample_ce` strobe from a fractional phase accumulator. It holds a CPU-writable shadow copy of all filter coefficients and commits them atomically to the active set only at a stereo-pair boundary. On request it flushes the filter state with a reset pulse.

## Interface
Parameters:
- `PHASE_W`, 32: phase accumulator width.
- `PHASE_INC`, 32'd6871948: accumulator increment per clk (ce rate = clk·INC/2^PHASE_W).
- `DEF_CX`, 40'h0: reset value of active/shadow `cx`.
- `DEF_CXN`, 24'h0: reset value of `{cx2,cx1,cx0}`.
- `DEF_CY`, 72'h0: reset value of `{cy2,cy1,cy0}`.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: register write strobe, one clk.
- `addr` in 5: register address, shared by write and read.
- `wr_data` in 8: write byte.
- `rd_data` out 8: combinational read of shadow/status at `addr`.
- `ce` out 1: filter compute strobe, single-clk pulse.
- `sample_ce` out 1: output-sample strobe, single-clk pulse.
- `filt_reset` out 1: active-high filter state reset.
- `cx` out 40: active base gain.
- `cx0`, `cx1`, `cx2` out 8 each: active X scale factors.
- `cy0`, `cy1`, `cy2` out 24 each: active Y coefficients.
- `pending` out 1: a commit is queued and not yet applied.

## Operation
- Register map (shadow, LSB byte first):
  - 0–4: `cx`.
  - 5–7: `cx0`–`cx2`.
  - 8–10: `cy0`.
  - 11–13: `cy1`.
  - 14–16: `cy2`.
  - 17: CTRL. Write bit0 = COMMIT, bit1 = FLUSH, bit2 = ENABLE (stored). Read returns `{5'b0, ENABLE, flush_q, pending}`.
  - 18–31: read 0, writes ignored.
- Writes to shadow bytes land on the `wr_en` edge and never touch active registers. Writes while `pending`=1 are legal; the last write before the swap wins.
- Strobe generation:
  - When ENABLE=1: acc <= acc + PHASE_INC every clk. `ce`=1 for the cycle after the carry out of acc.
  - When ENABLE=0: acc, `ce` and `sample_ce` are held at 0.
  - Internal `ch` toggles on each `ce`. It starts at 0 and mirrors the filter's channel phase.
  - `sample_ce` = `ce & ch` (second pulse of each pair).
- Commit FSM states:
  - IDLE. A CTRL write with COMMIT=1 sets `pending` and latches FLUSH into `flush_q`, then goes to WAIT.
  - WAIT. Swap shadow→active on the edge where `sample_ce`=1, or on the next edge if ENABLE=0. Clear `pending`. Go to FLUSH if `flush_q`, otherwise IDLE.
  - FLUSH. Drive `filt_reset`=1 for exactly 2 clks and reset `ch` to 0. Return to IDLE and clear `flush_q`.
- COMMIT while in WAIT re-latches FLUSH (OR-ed) and stays in WAIT. COMMIT while in FLUSH queues one more commit.
- ENABLE cleared during WAIT: the swap occurs on the next edge.

## Timing
- Reset values:
  - active = shadow = DEF_* parameters.
  - acc=0, ch=0, ENABLE=0.
  - `ce`, `sample_ce`, `pending`, `filt_reset` all 0; state IDLE.
- `ce` and `sample_ce` are registered outputs: 1 clk after the accumulator carry.
- Write → `pending`=1: 1 clk.
- Swap → new values on coefficient outputs: same edge that samples `sample_ce`. The next `ce` (ch=0) uses the new set, so a pair never mixes old and new coefficients.
- `ce` is suppressed while `filt_reset`=1 and the carry is held.
- Minimum `ce` spacing is 2 clks (PHASE_INC < 2^(PHASE_W-1)); larger increments are unsupported.
- `reset_n` deasserted mid-WAIT discards the commit; active reverts to DEF_*.

## Structure
- Shared package `iir_ctrl_pkg` holds:
  - register address constants;
  - CTRL bit positions;
  - FSM state enum (IDLE, WAIT, FLUSH);
  - a packed coefficient struct (cx, cx0–2, cy0–2; 136 bits).
- Sub-module `iir_ce_gen`: phase accumulator, `ch` toggle, `ce`/`sample_ce` generation, with enable and hold inputs.
- The register file and commit FSM stay in the top module.

## Test plan
- Reset, then ENABLE=1 with PHASE_INC=2^30 → `ce` every 4 clks; `sample_ce` on every second `ce`; all coefficient outputs equal DEF_*.
- Write `cy0` = 0x123456 to addr 8–10 without COMMIT → `cy0` output unchanged; `rd_data` at addr 9 reads 0x34.
- Write COMMIT at an arbitrary phase → `pending`=1 next clk; new `cy0` appears exactly on the `sample_ce` edge; the following two `ce` pulses both see 0x123456.
- COMMIT|FLUSH → swap occurs, then `filt_reset` is high for 2 clks; no `ce` during it; the next `ce` has ch=0.
- ENABLE=0, then COMMIT → swap on the next edge; `pending` is high for 1 clk.
- Assert `reset_n` low during WAIT → `pending`=0 and outputs equal DEF_* immediately (asynchronously).
